// File: rtl/dma_priority_arbiter.sv
// dma_priority_arbiter: hold-request / grant arbiter for four DMA channels with fixed or rotating priority
module dma_priority_arbiter #(
  parameter int NCH          = 4,
  parameter int HOLD_TIMEOUT = 15
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [NCH-1:0] i_dreq,
  input  logic [NCH-1:0] i_soft_req,
  input  logic [NCH-1:0] i_mask,
  input  logic           i_rotating,
  input  logic           i_hlda,
  input  logic           i_tc,
  output logic           o_hrq,
  output logic [NCH-1:0] o_dack,
  output logic [1:0]     o_channel,
  output logic           o_busy,
  output logic [NCH-1:0] o_soft_clr,
  output logic           o_timeout
);
  typedef enum logic [1:0] {IDLE, WAIT_HLDA, ACTIVE, RELEASE} state_t;
  state_t           r_state, w_nstate;
  logic [7:0]       r_cnt, w_cnt_d;
  logic [1:0]       r_last, w_last_d, w_win, w_idx, w_ch_d;
  logic [NCH-1:0]   w_pend, w_dack_d, w_soft_clr_d;
  logic             w_hrq_d, w_timeout_d, w_any, w_exit, w_expire;
  assign w_pend   = (i_dreq & ~i_mask) | i_soft_req;
  assign w_any    = |w_pend;
  assign w_expire = r_cnt == 8'(HOLD_TIMEOUT - 1);
  // Soft requests keep the channel pending, so only TC or HLDA loss ends them.
  assign w_exit   = i_tc | ~i_hlda | ~w_pend[r_channel_q()];
  assign o_busy   = r_state != IDLE;
  function automatic logic [1:0] r_channel_q();
    return o_channel;
  endfunction
  // Lowest search offset wins; rotating search starts just after the last serviced channel.
  always_comb begin
    w_win = '0;
    w_idx = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      w_idx = i_rotating ? r_last + 2'(k + 1) : 2'(k);
      if (w_pend[w_idx]) w_win = w_idx;
    end
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_last     <= 2'd3;
      o_hrq      <= 1'b0;
      o_dack     <= '0;
      o_channel  <= '0;
      o_soft_clr <= '0;
      o_timeout  <= 1'b0;
    end else begin
      r_state    <= w_nstate;
      r_cnt      <= w_cnt_d;
      r_last     <= w_last_d;
      o_hrq      <= w_hrq_d;
      o_dack     <= w_dack_d;
      o_channel  <= w_ch_d;
      o_soft_clr <= w_soft_clr_d;
      o_timeout  <= w_timeout_d;
    end
  end
  always_comb begin
    w_nstate = r_state;
    case (r_state)
      IDLE:      w_nstate = w_any ? WAIT_HLDA : IDLE;
      WAIT_HLDA: w_nstate = !w_any ? IDLE : i_hlda ? ACTIVE : w_expire ? IDLE : WAIT_HLDA;
      ACTIVE:    w_nstate = w_exit ? RELEASE : ACTIVE;
      RELEASE:   w_nstate = IDLE;
      default:   w_nstate = IDLE;
    endcase
  end
  always_comb begin
    w_hrq_d      = w_nstate == WAIT_HLDA || w_nstate == ACTIVE;
    w_dack_d     = w_nstate != ACTIVE ? '0 : r_state == WAIT_HLDA ? NCH'(1) << w_win : o_dack;
    w_ch_d       = r_state == WAIT_HLDA && w_nstate == ACTIVE ? w_win : o_channel;
    w_soft_clr_d = r_state == ACTIVE && i_tc && i_soft_req[o_channel] ? NCH'(1) << o_channel : '0;
    w_timeout_d  = r_state == WAIT_HLDA && w_any && !i_hlda && w_expire;
    w_cnt_d      = r_state == WAIT_HLDA ? r_cnt + 8'd1 : '0;
    w_last_d     = r_state == ACTIVE && w_nstate == RELEASE ? o_channel : r_last;
  end
endmodule

// File: tb/tb_dma_priority_arbiter.sv
// tb_dma_priority_arbiter: directed vectors with hand-computed expectations for dma_priority_arbiter
module tb_dma_priority_arbiter;
  logic       clk = 1'b0, rst = 1'b1;
  logic [3:0] dreq = '0, soft_req = '0, mask = '0;
  logic       rotating = 1'b0, hlda = 1'b0, tc = 1'b0;
  logic       hrq, busy, timeout;
  logic [3:0] dack, soft_clr;
  logic [1:0] channel;
  int checks = 0, failures = 0;
  int exp_ch [5] = '{0, 1, 2, 3, 0};
  dma_priority_arbiter #(.NCH(4), .HOLD_TIMEOUT(15)) dut (
    .i_clk(clk), .i_rst(rst), .i_dreq(dreq), .i_soft_req(soft_req), .i_mask(mask),
    .i_rotating(rotating), .i_hlda(hlda), .i_tc(tc), .o_hrq(hrq), .o_dack(dack),
    .o_channel(channel), .o_busy(busy), .o_soft_clr(soft_clr), .o_timeout(timeout)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
  initial begin
    #1;
    check("rst_hrq", 32'(hrq), 0);
    check("rst_dack", 32'(dack), 0);
    check("rst_ch", 32'(channel), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_sclr", 32'(soft_clr), 0);
    check("rst_tmo", 32'(timeout), 0);
    step();
    rst = 1'b0;
    // fixed priority, HLDA tied high
    dreq = 4'b0110; hlda = 1'b1;
    step();
    check("fx_hrq1", 32'(hrq), 1);
    check("fx_dack1", 32'(dack), 0);
    check("fx_busy1", 32'(busy), 1);
    step();
    check("fx_dack2", 32'(dack), 4'b0010);
    check("fx_ch2", 32'(channel), 1);
    dreq = 4'b0000;
    step();
    check("fx_rel_dack", 32'(dack), 0);
    check("fx_rel_hrq", 32'(hrq), 0);
    check("fx_rel_busy", 32'(busy), 1);
    check("fx_rel_sclr", 32'(soft_clr), 0);
    step();
    check("fx_idle_busy", 32'(busy), 0);
    check("fx_idle_ch", 32'(channel), 1);
    // rotating order with all channels requesting
    do_reset();
    rotating = 1'b1; dreq = 4'b1111; hlda = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rot_wait_hrq", 32'(hrq), 1);
      check("rot_wait_dack", 32'(dack), 0);
      step();
      check("rot_dack", 32'(dack), 32'(1) << exp_ch[i]);
      check("rot_ch", 32'(channel), 32'(exp_ch[i]));
      tc = 1'b1;
      step();
      tc = 1'b0;
      check("rot_rel_dack", 32'(dack), 0);
      check("rot_rel_hrq", 32'(hrq), 0);
      check("rot_rel_sclr", 32'(soft_clr), 0);
      step();
      check("rot_idle_busy", 32'(busy), 0);
    end
    // software request on masked channel, TC coinciding with HLDA loss
    do_reset();
    rotating = 1'b0; dreq = '0; mask = 4'b1111; soft_req = 4'b1000; hlda = 1'b1;
    step();
    step();
    check("sw_dack", 32'(dack), 4'b1000);
    check("sw_ch", 32'(channel), 3);
    mask = 4'b0000; dreq = 4'b0001;
    step();
    check("sw_excl_dack", 32'(dack), 4'b1000);
    check("sw_excl_ch", 32'(channel), 3);
    dreq = '0; tc = 1'b1; hlda = 1'b0;
    step();
    tc = 1'b0; soft_req = '0;
    check("sw_sclr", 32'(soft_clr), 4'b1000);
    check("sw_tc_dack", 32'(dack), 0);
    step();
    check("sw_sclr_off", 32'(soft_clr), 0);
    // pending request withdrawn before HLDA
    step();
    dreq = 4'b0001;
    step();
    check("wd_hrq", 32'(hrq), 1);
    dreq = '0;
    step();
    check("wd_hrq_off", 32'(hrq), 0);
    check("wd_busy", 32'(busy), 0);
    check("wd_dack", 32'(dack), 0);
    // hold timeout
    dreq = 4'b0001;
    step();
    check("to_hrq1", 32'(hrq), 1);
    for (int e = 2; e <= 15; e++) begin
      step();
      check("to_wait_tmo", 32'(timeout), 0);
    end
    check("to_wait_hrq", 32'(hrq), 1);
    step();
    check("to_pulse", 32'(timeout), 1);
    check("to_hrq_off", 32'(hrq), 0);
    check("to_busy", 32'(busy), 0);
    check("to_dack", 32'(dack), 0);
    dreq = '0;
    step();
    check("to_pulse_end", 32'(timeout), 0);
    step();
    // HLDA loss while channel 2 active
    hlda = 1'b1; dreq = 4'b0100;
    step();
    step();
    check("ab_dack", 32'(dack), 4'b0100);
    hlda = 1'b0;
    step();
    check("ab_dack_off", 32'(dack), 0);
    check("ab_sclr", 32'(soft_clr), 0);
    check("ab_busy", 32'(busy), 1);
    dreq = '0;
    step();
    check("ab_idle", 32'(busy), 0);
    // reset mid-ACTIVE; last serviced was ch2, reset must restart search at ch0
    rotating = 1'b1; dreq = 4'b0100; hlda = 1'b1;
    step();
    step();
    check("mr_dack", 32'(dack), 4'b0100);
    #1 rst = 1'b1;
    #1;
    check("mr_dack_off", 32'(dack), 0);
    check("mr_hrq_off", 32'(hrq), 0);
    check("mr_busy_off", 32'(busy), 0);
    check("mr_ch", 32'(channel), 0);
    step();
    rst = 1'b0; dreq = 4'b1111;
    step();
    step();
    check("mr_rot_dack", 32'(dack), 4'b0001);
    check("mr_rot_ch", 32'(channel), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
